// File: rtl/rv_lsu.sv
// Load/store unit: one byte/half/word access per transaction over a word-wide
// memory handshake, with alignment/funct3 checks and a WAIT-state timeout.
module rv_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_write,
   output logic        mem_addr_ready,
   input  logic [31:0] mem_rdata,
   input  logic        mem_data_ready
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t      r_state, w_next;
   logic        r_ready, r_resp_valid, r_mem_write, r_addr_rdy, r_write;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off, r_err;
   logic [7:0]  r_cnt;
   logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
   logic [3:0]  r_mem_wstrb;

   logic        w_accept, w_illegal, w_misal, w_timeout;
   logic [7:0]  w_cnt_inc;
   logic [31:0] w_shift, w_ext, w_st_data;
   logic [3:0]  w_st_strb;

   always_comb begin
      w_illegal = 1'b1;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = req_write;
         default:                w_illegal = 1'b1;
      endcase
      w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

      case (req_funct3[1:0])
         2'b00: begin
            w_st_strb = 4'b0001 << req_addr[1:0];
            w_st_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_st_strb = 4'b0011 << req_addr[1:0];
            w_st_data = {2{req_wdata[15:0]}};
         end
         default: begin
            w_st_strb = 4'b1111;
            w_st_data = req_wdata;
         end
      endcase
      if (!req_write) begin
         w_st_strb = '0;
         w_st_data = '0;
      end

      w_shift = mem_rdata >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  w_ext = {{24{w_shift[7]}},  w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'd0, w_shift[7:0]};
         3'b101:  w_ext = {16'd0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase

      w_cnt_inc = r_cnt + 8'd1;
      w_accept  = (r_state == S_IDLE) && r_ready && req_valid;
      w_timeout = (r_state == S_WAIT) && !mem_data_ready && (w_cnt_inc == 8'(TIMEOUT));

      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (w_illegal || w_misal) ? S_RESP : S_REQ;
         S_REQ:  w_next = S_WAIT;
         S_WAIT: if (mem_data_ready || w_timeout) w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobe-type outputs are registered from w_next so they line up with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_ready      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_mem_write  <= 1'b0;
         r_addr_rdy   <= 1'b0;
         r_write      <= 1'b0;
         r_funct3     <= '0;
         r_off        <= '0;
         r_err        <= '0;
         r_cnt        <= '0;
         r_rdata      <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wstrb  <= '0;
      end else begin
         r_state      <= w_next;
         r_ready      <= (w_next == S_IDLE);
         r_resp_valid <= (w_next == S_RESP);
         r_addr_rdy   <= (w_next == S_REQ);
         r_mem_write  <= (w_next == S_REQ) && req_write;
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_write  <= req_write;
               r_funct3 <= req_funct3;
               r_off    <= req_addr[1:0];
               r_cnt    <= '0;
               if (w_illegal || w_misal) begin
                  r_rdata <= '0;
                  r_err   <= w_illegal ? 2'b10 : 2'b01;
               end else begin
                  r_mem_addr  <= {req_addr[31:2], 2'b00};
                  r_mem_wstrb <= w_st_strb;
                  r_mem_wdata <= w_st_data;
               end
            end
            S_WAIT: begin
               if (mem_data_ready) begin
                  r_rdata <= r_write ? '0 : w_ext;
                  r_err   <= 2'b00;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_timeout) begin
                     r_rdata <= '0;
                     r_err   <= 2'b11;
                  end
               end
            end
            S_RESP: r_cnt <= '0;
            default: ;
         endcase
      end
   end

   assign req_ready      = r_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_rdata     = r_rdata;
   assign resp_err       = r_err;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign mem_wstrb      = r_mem_wstrb;
   assign mem_write      = r_mem_write;
   assign mem_addr_ready = r_addr_rdy;

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized bench for rv_lsu against a byte-lane reference model of the
// memory and the load/store rules, plus the directed scenarios.
module tb_rv_lsu;
   localparam int unsigned TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_write, mem_addr_ready;
   logic [31:0] mem_rdata;
   logic        mem_data_ready;

   logic [31:0] mem_model [0:127];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   rv_lsu #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_write(mem_write), .mem_addr_ready(mem_addr_ready),
      .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned f_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [1:0] f_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      logic legal;
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'b10;
      if ((a % f_size(f3)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] word, val;
      int unsigned sz, off;
      word = mem_model[a[8:2]];
      sz   = f_size(f3);
      off  = a % 4;
      val  = '0;
      for (int unsigned i = 0; i < sz; i++)
         val |= ((word >> (8 * (off + i))) & 32'hFF) << (8 * i);
      if (!f3[2] && sz < 4 && val[8 * sz - 1])
         val = val - (32'd1 << (8 * sz));
      return val;
   endfunction

   task automatic mem_apply();
      for (int unsigned i = 0; i < 4; i++)
         if (mem_wstrb[i] && mem_addr < 32'h200)
            mem_model[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
   endtask

   // lat = WAIT cycle in which memory answers; 0 = never answers.
   task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int unsigned lat,
                          output logic [31:0] o_rdata, output logic [1:0] o_err);
      logic [1:0]  e_err;
      logic [31:0] e_rdata, e_wdata, hold_addr, hold_wdata;
      logic [3:0]  e_strb, hold_strb;
      int unsigned sz, off, resp_j, e_j;
      logic        got;
      e_err = f_err(wr, f3, a);
      @(negedge clk);
      chk("req_ready", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      if (e_err != 2'b00) begin
         chk("err_resp_valid", resp_valid, 1);
         chk("err_no_addr_ready", mem_addr_ready, 0);
         chk("err_no_write", mem_write, 0);
         chk("err_code", resp_err, e_err);
         chk("err_rdata", resp_rdata, 0);
         e_rdata = '0;
      end else begin
         chk("req_addr_ready", mem_addr_ready, 1);
         chk("req_mem_addr", mem_addr, {a[31:2], 2'b00});
         chk("req_mem_write", mem_write, wr);
         if (wr) begin
            sz = f_size(f3); off = a % 4;
            e_strb = '0; e_wdata = '0;
            for (int unsigned i = 0; i < 4; i++) begin
               e_strb[i] = (i >= off) && (i < off + sz);
               e_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
            end
            chk("st_wstrb", mem_wstrb, e_strb);
            chk("st_wdata", mem_wdata, e_wdata);
            mem_apply();
         end else begin
            chk("ld_wstrb", mem_wstrb, 0);
         end
         hold_addr = mem_addr; hold_strb = mem_wstrb; hold_wdata = mem_wdata;
         e_rdata = wr ? 32'd0 : f_load(f3, a);
         if (lat == 0 || lat > TMO) begin
            e_err = 2'b11; e_rdata = '0; e_j = TMO + 1;
         end else begin
            e_j = lat + 1;
         end
         got = 1'b0; resp_j = 0;
         for (int unsigned j = 1; j <= TMO + 4 && !got; j++) begin
            @(negedge clk);
            if (resp_valid) begin
               got = 1'b1; resp_j = j;
            end else begin
               chk("wait_addr_ready", mem_addr_ready, 0);
               chk("wait_write", mem_write, 0);
               chk("wait_hold", {hold_addr ^ mem_addr, hold_wdata ^ mem_wdata},
                    {hold_strb ^ mem_wstrb, 28'd0});
               if (j == lat) begin
                  mem_data_ready = 1'b1;
                  mem_rdata = mem_model[mem_addr[8:2]];
               end else begin
                  mem_data_ready = 1'b0;
                  mem_rdata = $urandom;
               end
            end
         end
         mem_data_ready = 1'b0;
         chk("resp_latency", resp_j, e_j);
         chk("resp_err", resp_err, e_err);
         chk("resp_rdata", resp_rdata, e_rdata);
      end
      o_rdata = resp_rdata;
      o_err   = resp_err;
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
      chk("resp_hold", {resp_rdata ^ e_rdata, 30'd0}, {resp_err ^ e_err, 30'd0});
   endtask

   logic [31:0] rd;
   logic [1:0]  er;
   int unsigned pulses;

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      mem_rdata = '0; mem_data_ready = 1'b0;
      for (int i = 0; i < 128; i++) mem_model[i] = $urandom;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_outs", {resp_valid, mem_write, mem_addr_ready, resp_err, mem_wstrb}, 0);
      chk("rst_data", resp_rdata | mem_addr | mem_wdata, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);

      mem_model[32'h40 >> 2] = 32'h8899AABB;
      run_txn(1'b0, 3'b000, 32'h41, 0, 1, rd, er); chk("LB_41", rd, 32'hFFFFFFAA); chk("LB_41_err", er, 0);
      run_txn(1'b0, 3'b100, 32'h43, 0, 1, rd, er); chk("LBU_43", rd, 32'h00000088);
      run_txn(1'b0, 3'b001, 32'h42, 0, 1, rd, er); chk("LH_42", rd, 32'hFFFF8899);
      run_txn(1'b0, 3'b101, 32'h40, 0, 1, rd, er); chk("LHU_40", rd, 32'h0000AABB);
      run_txn(1'b0, 3'b010, 32'h40, 0, 1, rd, er); chk("LW_40", rd, 32'h8899AABB);

      mem_model[32'h100 >> 2] = 32'h0;
      run_txn(1'b1, 3'b000, 32'h102, 32'h123456CD, 1, rd, er); chk("SB_rdata", rd, 0);
      run_txn(1'b0, 3'b010, 32'h100, 0, 1, rd, er); chk("LW_100", rd, 32'h00CD0000);

      run_txn(1'b0, 3'b010, 32'h102, 0, 1, rd, er); chk("LW_mis", er, 2'b01);
      run_txn(1'b0, 3'b011, 32'h40, 0, 1, rd, er); chk("f3_011", er, 2'b10);
      run_txn(1'b0, 3'b011, 32'h3, 0, 1, rd, er); chk("f3_011_mis", er, 2'b10);
      run_txn(1'b1, 3'b001, 32'h41, 32'hFFFF, 1, rd, er); chk("SH_mis", er, 2'b01);

      run_txn(1'b0, 3'b010, 32'h40, 0, 0, rd, er); chk("timeout_err", er, 2'b11);
      run_txn(1'b0, 3'b010, 32'h40, 0, 1, rd, er); chk("after_timeout", rd, 32'h8899AABB);

      // Stray mem_data_ready while idle must not produce a response.
      @(negedge clk);
      mem_data_ready = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_ready_ignored", resp_valid, 0);
      chk("idle_still_ready", req_ready, 1);
      mem_data_ready = 1'b0;

      // Reset in the middle of a store's WAIT phase.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h104; req_wdata = 32'hDEADBEEF;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstw_write", mem_write, 1);
      mem_apply();
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rstw_ctrl", {req_ready, resp_valid, mem_write, mem_addr_ready, resp_err, mem_wstrb}, 0);
      chk("rstw_data", resp_rdata | mem_addr | mem_wdata, 0);
      pulses = 0;
      @(negedge clk); if (resp_valid) pulses++;
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      chk("rstw_no_resp", pulses, 0);
      chk("rstw_ready", req_ready, 1);
      run_txn(1'b0, 3'b010, 32'h104, 0, 1, rd, er); chk("rstw_LW", rd, 32'hDEADBEEF);

      for (int t = 0; t < 150; t++) begin
         logic        w;
         logic [2:0]  f;
         logic [31:0] a, d;
         int unsigned l;
         w = 1'($urandom_range(0, 1));
         f = 3'($urandom_range(0, 7));
         a = $urandom_range(0, 511);
         d = $urandom;
         l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TMO + 3) : $urandom_range(1, 4);
         run_txn(w, f, a, d, l, rd, er);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
